// File: rtl/text_lcd_refresh_ctrl.sv
// HD44780-style character LCD controller: runs the power-up command sequence,
// then copies a host-writable character buffer onto the display rows.
module text_lcd_refresh_ctrl #(
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int EN_W     = 4,
  parameter int GAP      = 2,
  parameter int CLR_WAIT = 8,
  parameter int RST_HOLD = 4,
  parameter int AUTO     = 1,
  localparam int NCHR    = ROWS * COLS,
  localparam int AW      = (NCHR > 1) ? $clog2(NCHR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          refresh_req,
  output logic          init_done,
  output logic          frame_done,
  output logic          lcd_en,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic [7:0]    lcd_db,
  output logic          lcd_rst
);

  localparam int TX_LEN = 1 + EN_W + GAP;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_RST_WAIT,
    S_INIT,
    S_CLR_WAIT,
    S_ROW_ADDR,
    S_CHAR,
    S_IDLE
  } state_t;

  localparam state_t DONE_ST = (AUTO != 0) ? S_ROW_ADDR : S_IDLE;

  state_t        state, state_n;
  logic [15:0]   cnt;
  logic [1:0]    init_idx, init_idx_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic [7:0]    db_q, db_n;
  logic          rs_q;
  logic          pend_q;
  logic          tx_end, tx_start, frame_end, idle_go;
  logic [7:0]    buf_q [NCHR];
  logic [AW-1:0] rd_idx;
  logic [7:0]    rd_byte;

  function automatic logic is_tx(input state_t s);
    return (s == S_INIT) || (s == S_ROW_ADDR) || (s == S_CHAR);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input int r);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'(COLS);
      default: return 8'(8'h40 + COLS);
    endcase
  endfunction

  assign tx_end  = is_tx(state) && (cnt == 16'(TX_LEN - 1));
  assign idle_go = (state == S_IDLE) && (state_n == S_ROW_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RST_WAIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    init_idx_n = init_idx;
    row_n      = row;
    col_n      = col;
    frame_end  = 1'b0;
    case (state)
      S_RST_WAIT: if (cnt == 16'(RST_HOLD - 1)) state_n = S_INIT;
      S_INIT: if (tx_end) begin
        if (init_idx == 2'd3) state_n = (CLR_WAIT > 0) ? S_CLR_WAIT : DONE_ST;
        else                  init_idx_n = init_idx + 2'd1;
      end
      S_CLR_WAIT: if (cnt == 16'(CLR_WAIT - 1)) state_n = DONE_ST;
      S_ROW_ADDR: if (tx_end) state_n = S_CHAR;
      S_CHAR: if (tx_end) begin
        if (col == CW'(COLS - 1)) begin
          col_n = '0;
          if (row == RW'(ROWS - 1)) begin
            row_n     = '0;
            frame_end = 1'b1;
            state_n   = DONE_ST;
          end else begin
            row_n   = row + RW'(1);
            state_n = S_ROW_ADDR;
          end
        end else begin
          col_n = col + CW'(1);
        end
      end
      S_IDLE:  if (pend_q) state_n = S_ROW_ADDR;
      default: state_n = S_RST_WAIT;
    endcase
    tx_start = is_tx(state_n) && ((state_n != state) || tx_end);
  end

  // Byte for the TX whose setup cycle starts at this edge; a write landing on
  // the same edge is forwarded so it shows up in this frame.
  always_comb begin
    rd_idx  = AW'(int'(row_n) * COLS + int'(col_n));
    rd_byte = (wr_en && (wr_addr == rd_idx)) ? wr_data : buf_q[rd_idx];
    case (state_n)
      S_INIT:     db_n = init_cmd(init_idx_n);
      S_ROW_ADDR: db_n = 8'h80 | row_base(int'(row_n));
      default:    db_n = rd_byte;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCHR; i++) buf_q[AW'(i)] <= 8'h20;
    end else if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(NCHR))) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      init_idx   <= '0;
      row        <= '0;
      col        <= '0;
      db_q       <= '0;
      rs_q       <= 1'b0;
      pend_q     <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      init_idx   <= init_idx_n;
      row        <= row_n;
      col        <= col_n;
      frame_done <= frame_end;
      pend_q     <= refresh_req | (pend_q & ~idle_go);
      if ((state_n != state) || tx_end) cnt <= '0;
      else if (state != S_IDLE)         cnt <= cnt + 16'd1;
      if (tx_start) begin
        db_q <= db_n;
        rs_q <= (state_n == S_CHAR);
      end
      if ((state == S_INIT || state == S_CLR_WAIT) &&
          (state_n == S_ROW_ADDR || state_n == S_IDLE))
        init_done <= 1'b1;
    end
  end

  always_comb begin
    lcd_rst = (state == S_RST_WAIT);
    lcd_rw  = 1'b0;
    lcd_en  = is_tx(state) && (cnt >= 16'd1) && (cnt <= 16'(EN_W));
    if (state == S_IDLE || state == S_RST_WAIT) begin
      lcd_rs = 1'b0;
      lcd_db = '0;
    end else begin
      lcd_rs = rs_q;
      lcd_db = db_q;
    end
  end

endmodule

// File: tb/tb_text_lcd_refresh_ctrl.sv
// Bench for text_lcd_refresh_ctrl: one AUTO=1 and one AUTO=0 instance driven
// by shared host stimulus, each checked against a frame-level reference model.
module tb_text_lcd_refresh_ctrl;

  localparam int COLS     = 16;
  localparam int ROWS     = 2;
  localparam int EN_W     = 4;
  localparam int GAP      = 2;
  localparam int CLR_WAIT = 8;
  localparam int RST_HOLD = 4;
  localparam int TX_LEN   = 1 + EN_W + GAP;
  localparam int NTX      = ROWS * (COLS + 1);
  localparam int NCHR     = ROWS * COLS;

  localparam bit [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  localparam bit [7:0] ROW_BASE  [4] = '{8'h00, 8'h40, 8'(COLS), 8'(8'h40 + COLS)};

  typedef struct {
    bit       rs;
    bit [7:0] db;
    int       at;
  } tx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       refresh_req = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  bit   [7:0] mbuf [NCHR];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane_id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", name, lane_id, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int AUTO_L = (g == 0) ? 1 : 0;
    logic       init_done, frame_done, lcd_en, lcd_rs, lcd_rw, lcd_rst;
    logic [7:0] lcd_db;
    tx_t        q[$];
    tx_t        cur;
    int         k, tx_at, j, end_at, done_at, mode, run;
    bit         pend, idle_m, exp_fd, exp_init, prev_en;
    bit         exp_rst = 1'b1;

    text_lcd_refresh_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .EN_W(EN_W), .GAP(GAP),
      .CLR_WAIT(CLR_WAIT), .RST_HOLD(RST_HOLD), .AUTO(AUTO_L)
    ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .refresh_req(refresh_req), .init_done(init_done), .frame_done(frame_done),
      .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db), .lcd_rst(lcd_rst)
    );

    function automatic void start_frame(input int at);
      mode  = 3;
      j     = 0;
      tx_at = at;
    endfunction

    // Model: mode 0 reset hold, 1 init cmds, 2 clear wait, 3 frame, 4 idle.
    always @(posedge clk) begin
      bit  req;
      tx_t it;
      int  r, c;
      if (rst) begin
        k = 0; mode = 0; pend = 0; idle_m = 0;
        exp_fd = 0; exp_init = 0; exp_rst = 1;
        q.delete();
      end else begin
        k++;
        req    = refresh_req;
        exp_fd = 0;
        if (idle_m && pend) begin
          idle_m = 0;
          pend   = req;
          start_frame(k);
        end else begin
          pend = pend | req;
        end
        if (mode == 0 && k == RST_HOLD) begin
          mode = 1; j = 0; tx_at = k; exp_rst = 0;
        end
        if (mode == 2 && k == done_at) begin
          exp_init = 1;
          if (AUTO_L != 0) start_frame(k);
          else begin mode = 4; idle_m = 1; end
        end
        if (mode == 3 && j == NTX && k == end_at) begin
          exp_fd = 1;
          if (AUTO_L != 0) start_frame(k);
          else begin mode = 4; idle_m = 1; end
        end
        if ((mode == 1 || (mode == 3 && j < NTX)) && k == tx_at) begin
          if (mode == 1) begin
            it.rs = 0; it.db = INIT_CMDS[j];
          end else begin
            r = j / (COLS + 1);
            c = j % (COLS + 1);
            if (c == 0) begin it.rs = 0; it.db = 8'h80 | ROW_BASE[r]; end
            else        begin it.rs = 1; it.db = mbuf[r * COLS + c - 1]; end
          end
          it.at = k;
          q.push_back(it);
          j++;
          tx_at += TX_LEN;
          if (mode == 1 && j == 4) begin mode = 2; done_at = tx_at + CLR_WAIT; end
          else if (mode == 3 && j == NTX) end_at = tx_at;
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        prev_en = 0;
        run     = 0;
      end else begin
        chk("frame_done", g, int'(frame_done), int'(exp_fd));
        chk("init_done", g, int'(init_done), int'(exp_init));
        chk("lcd_rst", g, int'(lcd_rst), int'(exp_rst));
        chk("lcd_rw", g, int'(lcd_rw), 0);
        if (lcd_en && !prev_en) begin
          if (q.size() == 0) chk("tx_expected", g, int'(q.size() > 0), 1);
          else begin
            cur = q.pop_front();
            chk("tx_start_cycle", g, k, cur.at + 1);
            chk("tx_rs", g, int'(lcd_rs), int'(cur.rs));
            chk("tx_db", g, int'(lcd_db), int'(cur.db));
          end
          run = 1;
        end else if (lcd_en) begin
          run++;
          chk("db_stable", g, int'(lcd_db), int'(cur.db));
        end else if (prev_en) begin
          chk("en_width", g, run, EN_W);
          run = 0;
        end
        if (!lcd_en && q.size() > 0 && k > q[0].at + 1) begin
          chk("tx_missing", g, k, q[0].at + 1);
          void'(q.pop_front());
        end
        prev_en = lcd_en;
      end
    end
  end

  task automatic drive(input bit we, input int addr, input bit [7:0] data, input bit rq);
    wr_en       = we;
    wr_addr     = 5'(addr);
    wr_data     = data;
    refresh_req = rq;
    if (we && addr < NCHR) mbuf[addr] = data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic wait_fd();
    int t = 0;
    while (lane[0].frame_done !== 1'b1 && t < 1000) begin
      idle(1);
      t++;
    end
    chk("frame_done_seen", 0, int'(lane[0].frame_done), 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_lcd_en", 0, int'(lane[0].lcd_en), 0);
    chk("rst_lcd_db", 0, int'(lane[0].lcd_db), 0);
    chk("rst_lcd_rs", 0, int'(lane[0].lcd_rs), 0);
    chk("rst_lcd_rst", 0, int'(lane[0].lcd_rst), 1);
    chk("rst_init_done", 0, int'(lane[0].init_done), 0);
    chk("rst_frame_done", 0, int'(lane[0].frame_done), 0);
    chk("rst_lcd_en", 1, int'(lane[1].lcd_en), 0);
    chk("rst_lcd_db", 1, int'(lane[1].lcd_db), 0);
    chk("rst_lcd_rst", 1, int'(lane[1].lcd_rst), 1);
    chk("rst_init_done", 1, int'(lane[1].init_done), 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < NCHR; i++) mbuf[i] = 8'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    drive(1'b1, 0, 8'h53, 1'b0);
    drive(1'b1, 1, 8'h4E, 1'b0);
    drive(1'b1, 2, 8'h41, 1'b0);
    drive(1'b1, 3, 8'h4B, 1'b0);
    drive(1'b1, 4, 8'h45, 1'b0);
    drive(1'b1, 31, 8'h39, 1'b0);
    idle(300);

    // Char 5 of row 0 has its setup edge 42 cycles after the frame_done edge.
    wait_fd();
    idle(41);
    drive(1'b1, 5, 8'h41, 1'b0);
    wait_fd();
    idle(42);
    drive(1'b1, 5, 8'h42, 1'b0);
    idle(300);

    drive(1'b0, 0, 8'h00, 1'b1);
    idle(120);
    drive(1'b0, 0, 8'h00, 1'b1);
    idle(700);

    for (int n = 0; n < 2000; n++)
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, NCHR - 1)),
            8'($urandom_range(32, 126)), $urandom_range(0, 299) == 0);
    idle(10);

    t = 0;
    while (lane[0].lcd_en !== 1'b1 && t < 100) begin
      idle(1);
      t++;
    end
    chk("en_high_before_reset", 0, int'(lane[0].lcd_en), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < NCHR; i++) mbuf[i] = 8'h20;
    #1 chk_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
